// File: rtl/cluster_imem_pkg.sv
// Shared constants and PC decode helpers for the cluster instruction-memory responder.
// Banks are word-interleaved: bank from PC[3:2], row from PC[11:4].
package cluster_imem_pkg;

    localparam int LANES       = 4;
    localparam int NUM_BANKS   = 4;
    localparam int DEPTH_WORDS = 1024;
    localparam int BANK_ROWS   = DEPTH_WORDS / NUM_BANKS;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

    function automatic logic [1:0] bank_of(input logic [31:0] pc);
        return 2'(pc >> 2);
    endfunction

    function automatic logic [7:0] row_of(input logic [31:0] pc);
        return 8'(pc >> 4);
    endfunction

    // A PC is usable only if word aligned and inside the instruction store.
    function automatic logic pc_ok(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc < BYTE_LIMIT);
    endfunction

endpackage

// File: rtl/cluster_imem_responder_if.sv
// Fetch and program-load bus between the cluster controller (master) and the
// instruction-memory responder (slave).
interface cluster_imem_responder_if;
    import cluster_imem_pkg::*;

    logic [32*LANES-1:0] PCsIM;
    logic [LANES-1:0]    InstReadEn;
    logic [32*LANES-1:0] instruction_mem;
    logic [LANES-1:0]    inst_valid;
    logic [LANES-1:0]    lane_busy;
    logic [LANES-1:0]    addr_err;
    logic                load_en;
    logic [31:0]         load_addr;
    logic [31:0]         load_data;

    modport master (
        output PCsIM, InstReadEn, load_en, load_addr, load_data,
        input  instruction_mem, inst_valid, lane_busy, addr_err
    );

    modport slave (
        input  PCsIM, InstReadEn, load_en, load_addr, load_data,
        output instruction_mem, inst_valid, lane_busy, addr_err
    );

endinterface

// File: rtl/imem_bank.sv
// One instruction bank: single-port synchronous RAM, one read or one write per
// cycle, registered read data. Contents are intentionally not reset.
module imem_bank
    import cluster_imem_pkg::*;
(
    input  logic        clk,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    logic [31:0] mem_q [BANK_ROWS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cluster_imem_responder.sv
// Four-lane instruction fetch responder: per-lane pending registers, per-bank
// round-robin arbitration with program-load priority, and held output words.
module cluster_imem_responder
    import cluster_imem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    cluster_imem_responder_if.slave bus
);

    logic [LANES-1:0] pend_q, pend_d;
    logic [LANES-1:0] rdValid_q, rdValid_d;
    logic [LANES-1:0] errValid_q, errValid_d;
    logic [LANES-1:0] grant;
    logic [31:0]      pendPc_q [LANES];
    logic [31:0]      pendPc_d [LANES];
    logic [31:0]      instHold_q [LANES];
    logic [31:0]      instOut [LANES];
    logic [31:0]      lanePc;
    logic [1:0]       rrPtr_q, rrPtr_d;

    logic [NUM_BANKS-1:0] bankRe, bankWe, bankTaken;
    logic [7:0]           bankAddr [NUM_BANKS];
    logic [31:0]          bankRdata [NUM_BANKS];
    logic [2:0]           contenders [NUM_BANKS];
    logic                 loadOk, anyConflict;
    logic [1:0]           loadBank, lane, laneBank;

    // Visiting lanes in rotation order from rrPtr lets the first pending lane per
    // bank win; a valid load claims its bank before any read is considered.
    always_comb begin
        grant       = '0;
        bankRe      = '0;
        bankWe      = '0;
        bankTaken   = '0;
        anyConflict = 1'b0;
        lane        = '0;
        laneBank    = '0;
        loadOk      = bus.load_en && pc_ok(bus.load_addr);
        loadBank    = bank_of(bus.load_addr);
        for (int b = 0; b < NUM_BANKS; b++) begin
            contenders[b] = '0;
            bankAddr[b]   = '0;
        end
        if (loadOk) begin
            bankWe[loadBank]    = 1'b1;
            bankTaken[loadBank] = 1'b1;
            bankAddr[loadBank]  = row_of(bus.load_addr);
        end
        for (int k = 0; k < LANES; k++) begin
            lane     = rrPtr_q + 2'(k);
            laneBank = bank_of(pendPc_q[lane]);
            if (pend_q[lane]) begin
                contenders[laneBank] = contenders[laneBank] + 3'd1;
                if (!bankTaken[laneBank]) begin
                    grant[lane]         = 1'b1;
                    bankTaken[laneBank] = 1'b1;
                    bankRe[laneBank]    = 1'b1;
                    bankAddr[laneBank]  = row_of(pendPc_q[lane]);
                end
            end
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (contenders[b] > 3'd1) begin
                anyConflict = 1'b1;
            end
        end
        rrPtr_d = anyConflict ? rrPtr_q + 2'd1 : rrPtr_q;
    end

    // Pending clears at grant, so the lane is free again in its valid cycle.
    // Bad PCs skip the banks and answer on the very next cycle.
    always_comb begin
        pend_d     = pend_q & ~grant;
        rdValid_d  = grant;
        errValid_d = '0;
        lanePc     = '0;
        for (int i = 0; i < LANES; i++) begin
            pendPc_d[i] = pendPc_q[i];
            lanePc      = bus.PCsIM[32*i +: 32];
            if (bus.InstReadEn[i] && !pend_q[i]) begin
                pendPc_d[i] = lanePc;
                if (pc_ok(lanePc)) begin
                    pend_d[i] = 1'b1;
                end else begin
                    errValid_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            instOut[i] = instHold_q[i];
            if (rdValid_q[i]) begin
                instOut[i] = bankRdata[bank_of(pendPc_q[i])];
            end else if (errValid_q[i]) begin
                instOut[i] = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            rdValid_q  <= '0;
            errValid_q <= '0;
            rrPtr_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                pendPc_q[i]   <= '0;
                instHold_q[i] <= '0;
            end
        end else begin
            pend_q     <= pend_d;
            rdValid_q  <= rdValid_d;
            errValid_q <= errValid_d;
            rrPtr_q    <= rrPtr_d;
            for (int i = 0; i < LANES; i++) begin
                pendPc_q[i]   <= pendPc_d[i];
                instHold_q[i] <= instOut[i];
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        imem_bank u_bank (
            .clk     (clk),
            .we_i    (bankWe[b]),
            .re_i    (bankRe[b]),
            .addr_i  (bankAddr[b]),
            .wdata_i (bus.load_data),
            .rdata_o (bankRdata[b])
        );
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign bus.instruction_mem[32*g +: 32] = instOut[g];
    end

    assign bus.inst_valid = rdValid_q | errValid_q;
    assign bus.addr_err   = errValid_q;
    assign bus.lane_busy  = pend_q;

endmodule

// File: tb/tb_cluster_imem_responder.sv
// Directed scenarios plus a randomized fetch phase checked against a word-array
// memory model and a per-lane outstanding-request scoreboard.
module tb_cluster_imem_responder;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] refMem [1024];
    logic [3:0]  outst;
    int          age [4];
    logic [31:0] expData [4];
    logic        expErr [4];

    always #5 clk = ~clk;

    cluster_imem_responder_if bus ();

    cluster_imem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic [127:0] pcs);
        bus.InstReadEn = en;
        bus.PCsIM      = pcs;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic loadWord(input logic [31:0] addr, input logic [31:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        refMem[addr[11:2]] = data;
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] laneData(input int i);
        return bus.instruction_mem[32*i +: 32];
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] pc);
        if (pc[1:0] == 2'b00 && pc < 32'h1000) return refMem[pc[11:2]];
        return 32'h0000_0013;
    endfunction

    initial begin
        logic [3:0]   busyExp [4];
        logic [3:0]   en;
        logic [127:0] pcs;
        logic [31:0]  pc;
        int           r;

        busyExp = '{4'hE, 4'hC, 4'h8, 4'h0};
        reset   = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        applyStimulus(4'h0, '0);
        tick();
        tick();
        checkOutput("rst_valid", 32'(bus.inst_valid), 32'h0);
        checkOutput("rst_busy", 32'(bus.lane_busy), 32'h0);
        checkOutput("rst_err", 32'(bus.addr_err), 32'h0);
        for (int i = 0; i < 4; i++) checkOutput("rst_data", laneData(i), 32'h0);
        reset = 1'b0;

        // Conflict-free fetch on all lanes
        for (int w = 0; w < 4; w++) loadWord(32'(4 * w), $urandom);
        applyStimulus(4'hF, {32'hC, 32'h8, 32'h4, 32'h0});
        tick();
        applyStimulus(4'h0, '0);
        checkOutput("t1_busy", 32'(bus.lane_busy), 32'hF);
        checkOutput("t1_early_valid", 32'(bus.inst_valid), 32'h0);
        tick();
        checkOutput("t1_valid", 32'(bus.inst_valid), 32'hF);
        checkOutput("t1_err", 32'(bus.addr_err), 32'h0);
        for (int i = 0; i < 4; i++) checkOutput("t1_data", laneData(i), refMem[i]);

        // Four lanes on bank 0 serialise in lane order
        doReset();
        loadWord(32'h10, $urandom);
        loadWord(32'h20, $urandom);
        loadWord(32'h30, $urandom);
        applyStimulus(4'hF, {32'h30, 32'h20, 32'h10, 32'h00});
        tick();
        applyStimulus(4'h0, '0);
        checkOutput("t2_busy0", 32'(bus.lane_busy), 32'hF);
        checkOutput("t2_valid0", 32'(bus.inst_valid), 32'h0);
        tick();
        for (int s = 0; s < 4; s++) begin
            checkOutput("t2_valid", 32'(bus.inst_valid), 32'(1 << s));
            checkOutput("t2_busy", 32'(bus.lane_busy), 32'(busyExp[s]));
            checkOutput("t2_data", laneData(s), refMem[4 * s]);
            tick();
        end

        // Misaligned and out-of-range PCs
        applyStimulus(4'b0110, {32'h0, 32'h1000, 32'h6, 32'h0});
        tick();
        applyStimulus(4'h0, '0);
        checkOutput("t3_valid", 32'(bus.inst_valid), 32'h6);
        checkOutput("t3_err", 32'(bus.addr_err), 32'h6);
        checkOutput("t3_nop1", laneData(1), 32'h0000_0013);
        checkOutput("t3_nop2", laneData(2), 32'h0000_0013);
        checkOutput("t3_hold0", laneData(0), refMem[0]);
        checkOutput("t3_hold3", laneData(3), refMem[12]);
        checkOutput("t3_busy", 32'(bus.lane_busy), 32'h0);
        tick();

        // Program load takes the bank from a pending read
        doReset();
        applyStimulus(4'h1, {96'h0, 32'h20});
        tick();
        applyStimulus(4'h0, '0);
        bus.load_en   = 1'b1;
        bus.load_addr = 32'h20;
        bus.load_data = 32'h00A4_8633;
        refMem[8]     = 32'h00A4_8633;
        tick();
        bus.load_en = 1'b0;
        checkOutput("t4_delayed", 32'(bus.inst_valid), 32'h0);
        tick();
        checkOutput("t4_valid", 32'(bus.inst_valid), 32'h1);
        checkOutput("t4_data", laneData(0), 32'h00A4_8633);

        // Reset with requests in flight
        applyStimulus(4'b0111, {32'h0, 32'h20, 32'h10, 32'h0});
        tick();
        applyStimulus(4'h0, '0);
        checkOutput("t5_busy", 32'(bus.lane_busy), 32'h7);
        reset = 1'b1;
        tick();
        checkOutput("t5_valid", 32'(bus.inst_valid), 32'h0);
        checkOutput("t5_busy_clr", 32'(bus.lane_busy), 32'h0);
        checkOutput("t5_data_clr", laneData(0), 32'h0);
        reset = 1'b0;
        tick();
        checkOutput("t5_no_valid", 32'(bus.inst_valid), 32'h0);
        applyStimulus(4'hF, {32'hC, 32'h8, 32'h4, 32'h0});
        tick();
        applyStimulus(4'h0, '0);
        tick();
        for (int i = 0; i < 4; i++) checkOutput("t5_ram_kept", laneData(i), refMem[i]);

        // Held request on a busy lane
        tick();
        applyStimulus(4'h1, {96'h0, 32'h4});
        tick();
        applyStimulus(4'h1, {96'h0, 32'h8});
        checkOutput("t6_busy", 32'(bus.lane_busy), 32'h1);
        tick();
        checkOutput("t6_valid1", 32'(bus.inst_valid), 32'h1);
        checkOutput("t6_data1", laneData(0), refMem[1]);
        applyStimulus(4'h1, {96'h0, 32'hC});
        tick();
        applyStimulus(4'h0, '0);
        checkOutput("t6_busy2", 32'(bus.lane_busy), 32'h1);
        checkOutput("t6_wait", 32'(bus.inst_valid), 32'h0);
        tick();
        checkOutput("t6_valid2", 32'(bus.inst_valid), 32'h1);
        checkOutput("t6_data2", laneData(0), refMem[3]);

        // Randomized traffic against the scoreboard
        doReset();
        for (int w = 0; w < 64; w++) loadWord(32'(4 * w), $urandom);
        outst = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (outst[i]) age[i]++;
                if (bus.inst_valid[i]) begin
                    checkOutput("rnd_expected_valid", 32'(outst[i]), 32'h1);
                    if (outst[i]) begin
                        checkOutput("rnd_data", laneData(i), expData[i]);
                        checkOutput("rnd_err", 32'(bus.addr_err[i]), 32'(expErr[i]));
                        if (expErr[i]) checkOutput("rnd_err_latency", 32'(age[i]), 32'd1);
                        else checks++;
                        if (!expErr[i]) begin
                            assert (age[i] >= 2 && age[i] <= 8) else begin
                                errors++;
                                $error("[TB] FAIL rnd_latency lane=%0d observed=%0d expected=2..8", i, age[i]);
                            end
                        end
                    end
                    outst[i] = 1'b0;
                end else if (outst[i] && age[i] > 8) begin
                    checkOutput("rnd_timeout", 32'(age[i]), 32'd8);
                    outst[i] = 1'b0;
                end
            end
            checkOutput("rnd_busy", 32'(bus.lane_busy), 32'(outst));
            en  = '0;
            pcs = '0;
            if (cyc < 400) begin
                for (int i = 0; i < 4; i++) begin
                    r = $urandom_range(0, 9);
                    if (r < 8) pc = 32'(4 * $urandom_range(0, 63));
                    else if (r == 8) pc = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
                    else pc = 32'h1000 + 32'(4 * $urandom_range(0, 255));
                    en[i] = 1'($urandom_range(0, 1));
                    pcs[32*i +: 32] = pc;
                    if (en[i] && !outst[i]) begin
                        outst[i]   = 1'b1;
                        age[i]     = 0;
                        expData[i] = refWord(pc);
                        expErr[i]  = (pc[1:0] != 2'b00) || (pc >= 32'h1000);
                    end
                end
            end
            applyStimulus(en, pcs);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
